// File: rtl/transport_pkg.sv
// Shared definitions for the incrementing test-pattern source and its
// receive-side checker.
//   DATA_W   : default pattern word width (ramp wraps modulo 2**DATA_W)
//   state_t  : checker lock state
//   next_val : successor of a pattern word, wrapping at all-ones
package transport_pkg;

    localparam int DATA_W = 8;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    function automatic logic [DATA_W-1:0] next_val(input logic [DATA_W-1:0] x);
        return x + 1'b1;
    endfunction

endpackage

// File: rtl/transport_checker_if.sv
// Bus between the pattern receiver and the checker: received stream,
// clear request, and the checker's status/counter outputs.
//   master : drives data_in, data_valid, clear; observes status
//   slave  : the checker itself
interface transport_checker_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic              clear;
    logic              locked;
    logic              err_pulse;
    logic              sticky_err;
    logic [CNT_W-1:0]  err_count;
    logic [CNT_W-1:0]  sample_count;
    logic [DATA_W-1:0] expected;

    modport master (
        output data_in, data_valid, clear,
        input  locked, err_pulse, sticky_err, err_count, sample_count, expected
    );

    modport slave (
        input  data_in, data_valid, clear,
        output locked, err_pulse, sticky_err, err_count, sample_count, expected
    );
endinterface

// File: rtl/transport_checker_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst : clock, asynchronous active-low reset
//   inc      : count one event this cycle
//   clr      : zero the counter; takes priority over inc
//   count    : current value, sticks at all-ones
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/transport_checker.sv
// Locks onto an incrementing byte ramp and checks each valid sample
// against the predicted next value.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : slave side of transport_checker_if
//              (data_in/data_valid/clear in; locked, err_pulse,
//               sticky_err, err_count, sample_count, expected out)
module transport_checker
    import transport_pkg::*;
#(
    parameter int DATA_W      = transport_pkg::DATA_W,
    parameter int CNT_W       = 16,
    parameter int LOCK_THRESH = 4,
    parameter int LOSS_THRESH = 3
) (
    input  logic                clk,
    input  logic                rst,
    transport_checker_if.slave  bus
);

    localparam int RUN_W  = $clog2(LOCK_THRESH + 1);
    localparam int MISS_W = $clog2(LOSS_THRESH + 1);

    function automatic logic [DATA_W-1:0] inc_word(input logic [DATA_W-1:0] x);
        return x + 1'b1;
    endfunction

    state_t              state, state_n;
    logic [RUN_W-1:0]    run, run_n;
    logic [MISS_W-1:0]   miss, miss_n;
    logic [DATA_W-1:0]   expected_q, exp_n;
    logic                pulse_n, err_pulse_q, sticky_q;
    logic                inc_err, inc_smp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= SEARCH;
            run         <= '0;
            miss        <= '0;
            expected_q  <= '0;
            err_pulse_q <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            state       <= state_n;
            run         <= run_n;
            miss        <= miss_n;
            expected_q  <= exp_n;
            err_pulse_q <= pulse_n;
            if (bus.clear) begin
                sticky_q <= 1'b0;
            end else if (pulse_n) begin
                sticky_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        run_n   = run;
        miss_n  = miss;
        exp_n   = expected_q;
        pulse_n = 1'b0;
        inc_err = 1'b0;
        inc_smp = 1'b0;
        if (bus.data_valid) begin
            unique case (state)
                SEARCH: begin
                    // run == 0 only right after reset: the reset value of
                    // expected must not count as an in-sequence predecessor.
                    if ((bus.data_in == expected_q) && (run != '0)) begin
                        run_n = run + 1'b1;
                    end else begin
                        run_n = RUN_W'(1);
                    end
                    exp_n = inc_word(bus.data_in);
                    if (run_n == RUN_W'(LOCK_THRESH)) begin
                        state_n = LOCKED;
                        miss_n  = '0;
                    end
                end
                LOCKED: begin
                    inc_smp = 1'b1;
                    // No reseed while locked: one bad byte costs one error.
                    exp_n   = inc_word(expected_q);
                    if (bus.data_in == expected_q) begin
                        miss_n = '0;
                    end else begin
                        pulse_n = 1'b1;
                        inc_err = 1'b1;
                        miss_n  = miss + 1'b1;
                        if (miss_n == MISS_W'(LOSS_THRESH)) begin
                            // The failing sample seeds the new search.
                            state_n = SEARCH;
                            run_n   = RUN_W'(1);
                            miss_n  = '0;
                            exp_n   = inc_word(bus.data_in);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc_err),
        .clr   (bus.clear),
        .count (bus.err_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_smp_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc_smp),
        .clr   (bus.clear),
        .count (bus.sample_count)
    );

    assign bus.locked     = (state == LOCKED);
    assign bus.err_pulse  = err_pulse_q;
    assign bus.sticky_err = sticky_q;
    assign bus.expected   = expected_q;

endmodule

// File: tb/tb_transport_checker.sv
// Self-checking bench for transport_checker: a table of stimulus/expected
// records driven through a scoreboard queue, plus hand-written sequences
// for the error build-up and asynchronous reset cases.
module tb_transport_checker;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    transport_checker_if #(.DATA_W(8), .CNT_W(16)) bus ();

    transport_checker #(
        .DATA_W(8), .CNT_W(16), .LOCK_THRESH(4), .LOSS_THRESH(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit       do_rst;
        bit       vld;
        bit       clr;
        bit [7:0] din;
        bit       locked;
        bit       pulse;
        bit       sticky;
        int       ec;
        int       sc;
        bit [7:0] expv;
        string    name;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(bit r, bit v, bit c, bit [7:0] d, bit l, bit p,
                                bit s, int ec, int sc, bit [7:0] e, string n);
        vec_t t;
        t.do_rst = r; t.vld = v; t.clr = c; t.din = d;
        t.locked = l; t.pulse = p; t.sticky = s;
        t.ec = ec; t.sc = sc; t.expv = e; t.name = n;
        return t;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", nm, act, req);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.data_valid = 1'b0;
        bus.clear      = 1'b0;
        bus.data_in    = '0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_vec(vec_t v);
        vec_t e;
        if (v.do_rst) do_reset();
        @(negedge clk);
        bus.data_valid = v.vld;
        bus.clear      = v.clr;
        bus.data_in    = v.din;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.name, ".locked"},   32'(bus.locked),       32'(e.locked));
        chk({e.name, ".pulse"},    32'(bus.err_pulse),    32'(e.pulse));
        chk({e.name, ".sticky"},   32'(bus.sticky_err),   32'(e.sticky));
        chk({e.name, ".err_cnt"},  32'(bus.err_count),    32'(e.ec));
        chk({e.name, ".smp_cnt"},  32'(bus.sample_count), 32'(e.sc));
        chk({e.name, ".expected"}, 32'(bus.expected),     32'(e.expv));
    endtask

    task automatic chk_all_zero(string nm);
        chk({nm, ".locked"},   32'(bus.locked),       0);
        chk({nm, ".pulse"},    32'(bus.err_pulse),    0);
        chk({nm, ".sticky"},   32'(bus.sticky_err),   0);
        chk({nm, ".err_cnt"},  32'(bus.err_count),    0);
        chk({nm, ".smp_cnt"},  32'(bus.sample_count), 0);
        chk({nm, ".expected"}, 32'(bus.expected),     0);
    endtask

    initial begin
        bus.data_valid = 1'b0;
        bus.clear      = 1'b0;
        bus.data_in    = '0;

        // Lock acquisition from reset
        vecs.push_back(mk(0,1,0,8'h10, 0,0,0,0,0,8'h11,"lock1"));
        vecs.push_back(mk(0,1,0,8'h11, 0,0,0,0,0,8'h12,"lock2"));
        vecs.push_back(mk(0,1,0,8'h12, 0,0,0,0,0,8'h13,"lock3"));
        vecs.push_back(mk(0,1,0,8'h13, 1,0,0,0,0,8'h14,"lock4"));
        // Wrap-around while locked
        vecs.push_back(mk(1,1,0,8'hF9, 0,0,0,0,0,8'hFA,"wlk1"));
        vecs.push_back(mk(0,1,0,8'hFA, 0,0,0,0,0,8'hFB,"wlk2"));
        vecs.push_back(mk(0,1,0,8'hFB, 0,0,0,0,0,8'hFC,"wlk3"));
        vecs.push_back(mk(0,1,0,8'hFC, 1,0,0,0,0,8'hFD,"wlk4"));
        vecs.push_back(mk(0,1,0,8'hFD, 1,0,0,0,1,8'hFE,"wrapFD"));
        vecs.push_back(mk(0,1,0,8'hFE, 1,0,0,0,2,8'hFF,"wrapFE"));
        vecs.push_back(mk(0,1,0,8'hFF, 1,0,0,0,3,8'h00,"wrapFF"));
        vecs.push_back(mk(0,1,0,8'h00, 1,0,0,0,4,8'h01,"wrap00"));
        vecs.push_back(mk(0,1,0,8'h01, 1,0,0,0,5,8'h02,"wrap01"));
        // Single corrupted byte
        vecs.push_back(mk(1,1,0,8'h3C, 0,0,0,0,0,8'h3D,"clk1"));
        vecs.push_back(mk(0,1,0,8'h3D, 0,0,0,0,0,8'h3E,"clk2"));
        vecs.push_back(mk(0,1,0,8'h3E, 0,0,0,0,0,8'h3F,"clk3"));
        vecs.push_back(mk(0,1,0,8'h3F, 1,0,0,0,0,8'h40,"clk4"));
        vecs.push_back(mk(0,1,0,8'h40, 1,0,0,0,1,8'h41,"cor40"));
        vecs.push_back(mk(0,1,0,8'h99, 1,1,1,1,2,8'h42,"cor99"));
        vecs.push_back(mk(0,1,0,8'h42, 1,0,1,1,3,8'h43,"cor42"));
        // Loss of lock and relock
        vecs.push_back(mk(1,1,0,8'h1C, 0,0,0,0,0,8'h1D,"llk1"));
        vecs.push_back(mk(0,1,0,8'h1D, 0,0,0,0,0,8'h1E,"llk2"));
        vecs.push_back(mk(0,1,0,8'h1E, 0,0,0,0,0,8'h1F,"llk3"));
        vecs.push_back(mk(0,1,0,8'h1F, 1,0,0,0,0,8'h20,"llk4"));
        vecs.push_back(mk(0,1,0,8'h55, 1,1,1,1,1,8'h21,"loss55"));
        vecs.push_back(mk(0,1,0,8'h66, 1,1,1,2,2,8'h22,"loss66"));
        vecs.push_back(mk(0,1,0,8'h77, 0,1,1,3,3,8'h78,"loss77"));
        vecs.push_back(mk(0,1,0,8'h78, 0,0,1,3,3,8'h79,"rel78"));
        vecs.push_back(mk(0,1,0,8'h79, 0,0,1,3,3,8'h7A,"rel79"));
        vecs.push_back(mk(0,1,0,8'h7A, 1,0,1,3,3,8'h7B,"rel7A"));
        // Gaps in data_valid, then clear colliding with a mismatch
        vecs.push_back(mk(0,1,0,8'h7B, 1,0,1,3,4,8'h7C,"gap7B"));
        vecs.push_back(mk(0,0,0,8'h00, 1,0,1,3,4,8'h7C,"gapIdle1"));
        vecs.push_back(mk(0,1,0,8'h7C, 1,0,1,3,5,8'h7D,"gap7C"));
        vecs.push_back(mk(0,0,0,8'hEE, 1,0,1,3,5,8'h7D,"gapIdle2"));
        vecs.push_back(mk(0,1,0,8'h7D, 1,0,1,3,6,8'h7E,"gap7D"));
        vecs.push_back(mk(0,1,1,8'h00, 1,1,0,0,0,8'h7F,"clrMis"));
        vecs.push_back(mk(0,1,0,8'h7F, 1,0,0,0,1,8'h80,"postClr"));

        // Reset state
        #1;
        chk_all_zero("rst0");
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i]);
        end

        // Build up five errors without losing lock (alternate bad/good)
        run_vec(mk(0,1,0,8'h00, 1,1,1,1,2, 8'h81,"e1"));
        run_vec(mk(0,1,0,8'h81, 1,0,1,1,3, 8'h82,"g1"));
        run_vec(mk(0,1,0,8'h00, 1,1,1,2,4, 8'h83,"e2"));
        run_vec(mk(0,1,0,8'h83, 1,0,1,2,5, 8'h84,"g2"));
        run_vec(mk(0,1,0,8'h00, 1,1,1,3,6, 8'h85,"e3"));
        run_vec(mk(0,1,0,8'h85, 1,0,1,3,7, 8'h86,"g3"));
        run_vec(mk(0,1,0,8'h00, 1,1,1,4,8, 8'h87,"e4"));
        run_vec(mk(0,1,0,8'h87, 1,0,1,4,9, 8'h88,"g4"));
        run_vec(mk(0,1,0,8'h00, 1,1,1,5,10,8'h89,"e5"));

        // Asynchronous reset between edges
        @(negedge clk);
        bus.data_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("asyncRst");
        @(negedge clk);
        rst = 1'b1;

        // Fresh lock needed after release
        run_vec(mk(0,1,0,8'h88, 0,0,0,0,0,8'h89,"post1"));
        run_vec(mk(0,1,0,8'h89, 0,0,0,0,0,8'h8A,"post2"));
        run_vec(mk(0,1,0,8'h8A, 0,0,0,0,0,8'h8B,"post3"));
        run_vec(mk(0,1,0,8'h8B, 1,0,0,0,0,8'h8C,"post4"));

        @(negedge clk);
        bus.data_valid = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/transport_checker.md
Name: transport_checker

Overview:
- Receive-side companion to the team's 8-bit incrementing test-pattern source. That source counts 0x00..0xFF and wraps to 0x00.
- This block samples the incoming byte stream and locks onto the ramp. It then checks every valid byte against the expected next value.
- Reports lock status, per-sample error pulses and saturating error/sample counters.
- Sits at the far end of the transport link, ahead of status/debug registers.

Parameters:
- DATA_W, 8, width of the pattern word; the ramp wraps modulo 2**DATA_W.
- CNT_W, 16, width of err_count and sample_count.
- LOCK_THRESH, 4, consecutive in-sequence samples needed to declare lock (min 2).
- LOSS_THRESH, 3, consecutive mismatches in LOCKED needed to drop lock (min 1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- data_in  in  DATA_W  received pattern word
- data_valid  in  1  data_in is valid this cycle; no backpressure
- clear  in  1  synchronous clear of err_count, sample_count and sticky_err
- locked  out  1  high while in LOCKED
- err_pulse  out  1  one-cycle pulse per mismatching sample while LOCKED
- sticky_err  out  1  set on any err_pulse; cleared only by clear or reset
- err_count  out  CNT_W  saturating count of mismatches while LOCKED
- sample_count  out  CNT_W  saturating count of valid samples while LOCKED
- expected  out  DATA_W  next value the checker expects

Behaviour:
- Reset is asynchronous and active-low. On rst low:
  - state = SEARCH
  - locked, err_pulse, sticky_err = 0
  - err_count, sample_count, expected = 0
  - internal run/miss counters = 0
- All outputs are registered. Any response to a sample at edge N is visible after edge N.
- Cycles with data_valid=0 are ignored: no state change, no counting, expected holds. err_pulse is 0 on those cycles.
- Expected increment is modulo 2**DATA_W: 0xFF -> 0x00 is in-sequence and is never an error.
- SEARCH state:
  - On each valid sample: if data_in == expected and run > 0, run++; otherwise run = 1.
  - expected := data_in + 1 on every valid sample (reseed).
  - When run reaches LOCK_THRESH, go to LOCKED and set locked=1 on that same edge. miss is cleared on entry.
  - No errors or samples are counted in SEARCH.
- LOCKED state, on each valid sample:
  - sample_count++ (saturates at all-ones).
  - Match (data_in == expected): miss = 0.
  - Mismatch: err_pulse = 1 for one cycle, err_count++ (saturating), sticky_err = 1, miss++.
  - In both cases expected := expected + 1. Expected is not reseeded, so a single corrupted byte produces exactly one error.
  - If miss reaches LOSS_THRESH: go to SEARCH, locked=0, run=1, expected := data_in + 1.
  - err_pulse still fires for that final mismatch.
- clear:
  - Zeroes err_count, sample_count and sticky_err on the next edge.
  - Does not affect state, locked or expected.
  - If clear coincides with a counted event, clear wins: the counter becomes 0, not 1. err_pulse still asserts.
- Saturation: counters stick at 2**CNT_W-1 and do not wrap.
- Reset asserted mid-stream returns the block to SEARCH immediately. After release, lock needs LOCK_THRESH fresh valid samples.

Decomposition:
- Shared package (transport_pkg), used by both source and checker:
  - localparam DATA_W
  - state enum {SEARCH, LOCKED}
  - function next_val(x) returning x + 1 modulo 2**DATA_W
- One natural sub-module: sat_counter (width param; inputs inc, clr). Instantiated twice, for err_count and sample_count.

Test Plan:
- Lock acquisition: ramp 0x10,0x11,0x12,0x13 with data_valid=1 -> locked rises after the 4th sample. expected=0x14, err_count=0.
- Wrap-around: locked, feed 0xFD..0xFF,0x00,0x01 -> no err_pulse, sample_count += 5, expected=0x02.
- Single corruption: locked, expected=0x40, feed 0x40,0x99,0x42 -> one err_pulse, on the 0x99 sample. err_count=1, sticky_err=1, still locked.
- Loss of lock: locked, expected=0x20, feed 0x55,0x66,0x77 -> three err_pulses, locked drops after the 3rd. expected=0x78, err_count=3. Then 0x78,0x79,0x7A -> relock after 4 in-sequence samples total.
- Gaps and clear:
  - Locked stream with data_valid toggling 1/0 -> idle cycles ignored, no errors.
  - clear pulse together with a mismatch -> err_count=0, err_pulse=1, sticky_err=0.
- Async reset mid-stream: assert rst low between clock edges while locked with err_count=5 -> all outputs 0 immediately, without waiting for a clock edge.
